uart_cmd_framer: RTL and testbench

- Sequencing controller that sits directly downstream of the UART receiver.
- Consumes received bytes via the receiver's rdy/clr_rdy handshake and assembles fixed 5-byte command frames: header, opcode, data high, data low, checksum.
- Validates the checksum and enforces an inter-byte timeout.
- Presents a held command (opcode + 16-bit data) to the control logic, with error reporting.

---
 rtl/uart_cmd_framer.sv | 155 +++++++++++++++
 tb/tb_uart_cmd_framer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_framer.sv
// Assembles 5-byte command frames (header, opcode, data hi, data lo, checksum)
// from a UART receiver and holds the last good command for the control logic.
module uart_cmd_framer #(
  parameter logic [7:0] HDR_BYTE  = 8'hA5,
  parameter int         TO_CYCLES = 100_000,
  parameter int         TO_W      = $clog2(TO_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rdy,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_data,
  output logic        cmd_rdy,
  input  logic        cmd_clr,
  output logic        err,
  output logic [1:0]  err_code
);

  // state | meaning
  // S_HDR | idle, waiting for HDR_BYTE; other bytes dropped silently
  // S_OP  | expecting opcode
  // S_DHI | expecting data high byte
  // S_DLO | expecting data low byte
  // S_CHK | expecting checksum (opcode + data_hi + data_lo, mod 256)
  typedef enum logic [2:0] {S_HDR, S_OP, S_DHI, S_DLO, S_CHK} state_e;

  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TO_CYCLES);
  localparam logic [1:0]      ERR_CSUM = 2'b01;
  localparam logic [1:0]      ERR_TO   = 2'b10;
  localparam logic [1:0]      ERR_OVR  = 2'b11;

  state_e          state_q, state_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic            clr_rdy_q, clr_rdy_d;
  logic            hold_q, hold_d;
  logic [7:0]      op_q, op_d;
  logic [7:0]      dhi_q, dhi_d;
  logic [7:0]      dlo_q, dlo_d;
  logic [7:0]      cmd_op_q, cmd_op_d;
  logic [15:0]     cmd_data_q, cmd_data_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            accept;
  logic [7:0]      csum;

  // hold_q blocks a level-style rx_rdy from being taken twice; it re-arms
  // only once the receiver drops rdy.
  assign accept = rx_rdy && !clr_rdy_q && !hold_q;
  assign csum   = op_q + dhi_q + dlo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HDR;
      timer_q    <= '0;
      clr_rdy_q  <= 1'b0;
      hold_q     <= 1'b0;
      op_q       <= '0;
      dhi_q      <= '0;
      dlo_q      <= '0;
      cmd_op_q   <= '0;
      cmd_data_q <= '0;
      cmd_rdy_q  <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      clr_rdy_q  <= clr_rdy_d;
      hold_q     <= hold_d;
      op_q       <= op_d;
      dhi_q      <= dhi_d;
      dlo_q      <= dlo_d;
      cmd_op_q   <= cmd_op_d;
      cmd_data_q <= cmd_data_d;
      cmd_rdy_q  <= cmd_rdy_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    clr_rdy_d  = accept;
    hold_d     = accept || (hold_q && rx_rdy);
    op_d       = op_q;
    dhi_d      = dhi_q;
    dlo_d      = dlo_q;
    cmd_op_d   = cmd_op_q;
    cmd_data_d = cmd_data_q;
    cmd_rdy_d  = cmd_rdy_q && !cmd_clr;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    if (accept || state_q == S_HDR) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TO_W'(1);
    end

    if (accept) begin
      case (state_q)
        S_HDR: begin
          if (rx_data == HDR_BYTE) state_d = S_OP;
        end
        S_OP: begin
          op_d    = rx_data;
          state_d = S_DHI;
        end
        S_DHI: begin
          dhi_d   = rx_data;
          state_d = S_DLO;
        end
        S_DLO: begin
          dlo_d   = rx_data;
          state_d = S_CHK;
        end
        S_CHK: begin
          state_d = S_HDR;
          if (rx_data == csum) begin
            cmd_op_d   = op_q;
            cmd_data_d = {dhi_q, dlo_q};
            cmd_rdy_d  = 1'b1;
            // a coincident cmd_clr counts as the consumer taking the old command
            if (cmd_rdy_q && !cmd_clr) begin
              err_d      = 1'b1;
              err_code_d = ERR_OVR;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end
        default: state_d = S_HDR;
      endcase
    end else if (state_q != S_HDR && timer_q == TO_MAX) begin
      state_d    = S_HDR;
      timer_d    = '0;
      err_d      = 1'b1;
      err_code_d = ERR_TO;
    end
  end

  assign clr_rdy  = clr_rdy_q;
  assign cmd_op   = cmd_op_q;
  assign cmd_data = cmd_data_q;
  assign cmd_rdy  = cmd_rdy_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: frame parsing, checksum, timeout,
// overrun, cmd_clr priority, reset mid-frame and held rx_rdy.
module tb_uart_cmd_framer;

  localparam int TO_CYC = 40;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rdy;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        cmd_rdy;
  logic        cmd_clr;
  logic        err;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;
  int clr_cnt = 0;
  int err_cnt = 0;

  logic       s_rdy0, s_clr1, s_err1, s_rdy1, s_clr2, s_err2;
  logic [1:0] s_code1;

  uart_cmd_framer #(.HDR_BYTE(8'hA5), .TO_CYCLES(TO_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .clr_rdy  (clr_rdy),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_rdy  (cmd_rdy),
    .cmd_clr  (cmd_clr),
    .err      (err),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr_rdy) clr_cnt++;
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte offered as a single-cycle rx_rdy pulse; cmd_clr optionally
  // driven in the same (acceptance) cycle.
  task automatic send_byte(input logic [7:0] b, input logic clr);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    cmd_clr = clr;
    s_rdy0  = cmd_rdy;
    @(negedge clk);
    rx_rdy  = 1'b0;
    cmd_clr = 1'b0;
    s_clr1  = clr_rdy;
    s_err1  = err;
    s_code1 = err_code;
    s_rdy1  = cmd_rdy;
    @(negedge clk);
    s_clr2  = clr_rdy;
    s_err2  = err;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic clr_last);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    send_byte(b3, 1'b0);
    send_byte(b4, clr_last);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    cmd_clr = 1'b1;
    @(negedge clk);
    cmd_clr = 1'b0;
  endtask

  initial begin
    int c0, e0, k;
    rst     = 1'b1;
    rx_data = 8'h00;
    rx_rdy  = 1'b0;
    cmd_clr = 1'b0;
    #12;
    check("rst_clr_rdy",  {31'd0, clr_rdy}, 32'd0);
    check("rst_cmd_rdy",  {31'd0, cmd_rdy}, 32'd0);
    check("rst_cmd_op",   {24'd0, cmd_op}, 32'd0);
    check("rst_cmd_data", {16'd0, cmd_data}, 32'd0);
    check("rst_err",      {31'd0, err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // good frame
    c0 = clr_cnt; e0 = err_cnt;
    send_frame(8'hA5, 8'h01, 8'h12, 8'h34, 8'h47, 1'b0);
    check("t1_clr_pulses", clr_cnt - c0, 32'd5);
    check("t1_clr_one_cycle", {30'd0, s_clr1, s_clr2}, 32'b10);
    check("t1_rdy_before", {31'd0, s_rdy0}, 32'd0);
    check("t1_rdy_after",  {31'd0, s_rdy1}, 32'd1);
    check("t1_cmd_op",   {24'd0, cmd_op}, 32'h01);
    check("t1_cmd_data", {16'd0, cmd_data}, 32'h1234);
    check("t1_no_err", err_cnt - e0, 32'd0);
    pulse_clr();
    check("t1_clr_drops_rdy", {31'd0, cmd_rdy}, 32'd0);

    // bad checksum
    e0 = err_cnt;
    send_frame(8'hA5, 8'h01, 8'h12, 8'h34, 8'h48, 1'b0);
    check("t2_err_pulse", {30'd0, s_err1, s_err2}, 32'b10);
    check("t2_err_code", {30'd0, s_code1}, 32'h1);
    check("t2_err_count", err_cnt - e0, 32'd1);
    check("t2_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("t2_cmd_op",   {24'd0, cmd_op}, 32'h01);
    check("t2_cmd_data", {16'd0, cmd_data}, 32'h1234);
    check("t2_code_held", {30'd0, err_code}, 32'h1);

    // junk before header, wrapping checksum
    e0 = err_cnt;
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_frame(8'hA5, 8'h80, 8'hFF, 8'hFF, 8'h7E, 1'b0);
    check("t3_no_err", err_cnt - e0, 32'd0);
    check("t3_cmd_op",   {24'd0, cmd_op}, 32'h80);
    check("t3_cmd_data", {16'd0, cmd_data}, 32'hFFFF);
    check("t3_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    pulse_clr();

    // inter-byte timeout
    send_byte(8'hA5, 1'b0);
    @(negedge clk);
    rx_data = 8'h02;
    rx_rdy  = 1'b1;
    @(posedge clk);
    #1 rx_rdy = 1'b0;
    k = 0;
    while (k < 3 * TO_CYC) begin
      @(posedge clk);
      k++;
      #1;
      if (err) break;
    end
    check("t4_to_latency", k, TO_CYC + 1);
    check("t4_to_code", {30'd0, err_code}, 32'h2);
    send_frame(8'hA5, 8'h03, 8'h00, 8'h01, 8'h04, 1'b0);
    check("t4_cmd_op",   {24'd0, cmd_op}, 32'h03);
    check("t4_cmd_data", {16'd0, cmd_data}, 32'h0001);
    check("t4_no_err_after", {31'd0, s_err1}, 32'd0);
    pulse_clr();

    // overrun
    send_frame(8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
    check("t5_first_rdy", {31'd0, cmd_rdy}, 32'd1);
    send_frame(8'hA5, 8'h02, 8'h00, 8'h05, 8'h07, 1'b0);
    check("t5_ovr_err", {31'd0, s_err1}, 32'd1);
    check("t5_ovr_code", {30'd0, s_code1}, 32'h3);
    check("t5_ovr_op",   {24'd0, cmd_op}, 32'h02);
    check("t5_ovr_data", {16'd0, cmd_data}, 32'h0005);
    check("t5_ovr_rdy", {31'd0, cmd_rdy}, 32'd1);
    pulse_clr();

    // cmd_clr coinciding with completion
    send_frame(8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
    e0 = err_cnt;
    send_frame(8'hA5, 8'h02, 8'h00, 8'h05, 8'h07, 1'b1);
    check("t5_clr_no_err", err_cnt - e0, 32'd0);
    check("t5_clr_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("t5_clr_op", {24'd0, cmd_op}, 32'h02);
    pulse_clr();

    // reset mid-frame
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_clr_rdy", {31'd0, clr_rdy}, 32'd0);
    check("t6_rst_cmd_op", {24'd0, cmd_op}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    e0 = err_cnt;
    send_frame(8'hA5, 8'h09, 8'h00, 8'h00, 8'h09, 1'b0);
    check("t6_cmd_op",   {24'd0, cmd_op}, 32'h09);
    check("t6_cmd_data", {16'd0, cmd_data}, 32'h0000);
    check("t6_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("t6_no_err", err_cnt - e0, 32'd0);
    pulse_clr();

    // held rx_rdy level: one acceptance only
    c0 = clr_cnt;
    @(negedge clk);
    rx_data = 8'hA5;
    rx_rdy  = 1'b1;
    repeat (3) @(negedge clk);
    rx_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_held_one_accept", clr_cnt - c0, 32'd1);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    check("t6_held_frame_op", {24'd0, cmd_op}, 32'h04);
    check("t6_held_frame_rdy", {31'd0, cmd_rdy}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
